uart_word_assembler: RTL and testbench
======================================

# uart_word_assembler

Byte-to-word packer directly downstream of the UART receiver. Takes the receiver's 8-bit data plus its single-cycle valid strobe, which has no backpressure, and packs four consecutive bytes little-endian into 32-bit words. Completed words are buffered in a small synchronous FIFO and presented on a valid/ready stream to the command or memory-loader logic. Loss of data is never silent: FIFO overflow is flagged sticky, and, when enabled, stalled partial words are discarded on an inter-byte timeout.

## Interface
- DEPTH, 4: FIFO depth in 32-bit words; power of two, minimum 2.
- TIMEOUT, 20'd34760: inter-byte timeout in clk cycles (about 4 byte times at wtime 16'h365); used only with the timeout feature.

- clk  in  1  system clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- rx_data  in  8  byte from the UART receiver.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in the same cycle.
- word_data  out  32  head-of-FIFO word; byte 0 is in [7:0], byte 3 in [31:24].
- word_valid  out  1  FIFO not empty.
- word_ready  in  1  consumer accepts the word; a pop occurs when word_valid && word_ready.
- level  out  $clog2(DEPTH)+1  words currently held.
- overflow  out  1  sticky; set when a completed word is dropped.
- dropped  out  1  one-cycle pulse when a partial word is discarded by timeout.

## Operation
- Reset values: word_data 0, word_valid 0, level 0, overflow 0, dropped 0, byte index 0, partial register 0, timeout counter TIMEOUT.
- Assembler FSM has four states, BYTE0 through BYTE3, encoded as a 2-bit index. On rx_valid in BYTEn, rx_data is stored into lane n and the index advances. BYTE3 wraps to BYTE0.
- Word completion: on rx_valid in BYTE3, the word {rx_data, lane2, lane1, lane0} is pushed into the FIFO on that same edge. The partial register is not cleared; lanes are overwritten by later bytes.
- Push acceptance: a push succeeds if the FIFO is not full, or if a pop occurs in the same cycle. The full-plus-pop case keeps level at DEPTH.
- Overflow: a push that does not succeed drops the word and sets overflow. overflow is held until reset. The assembler continues with BYTE0; FIFO contents are unaffected.
- Simultaneous push and pop with the FIFO neither empty nor full: level is unchanged and ordering is preserved.
- Pop on an empty FIFO cannot occur, because word_valid is 0. word_ready is ignored when word_valid is 0.
- Pointers are $clog2(DEPTH) bits wide and wrap naturally. level is computed as a separate counter, not derived from the pointers.
- Reset asserted mid-word or with the FIFO occupied discards everything. No output pulses occur during reset.

## Timing
- Latency: word_valid rises 1 cycle after the edge that captured byte 3, when the FIFO was empty. word_data is valid in that same cycle (registered, first-word fall-through).
- word_data and word_valid are stable while word_valid && !word_ready.
- After a pop, the next word, if present, appears on the following cycle. Back-to-back pops sustain 1 word per cycle.
- level updates 1 cycle after the push or pop edge.
- rx_valid strobes are at least 2 cycles apart (guaranteed by the UART bit rate). The block still accepts strobes on consecutive cycles.
- dropped is a single-cycle pulse, registered, asserted on the cycle after the counter reaches 0.

## Configuration
- Macro: UART_WORD_TIMEOUT_EN.
- Defined:
  - A 20-bit counter reloads to TIMEOUT on every rx_valid.
  - The counter decrements each cycle while the index is not BYTE0, and holds while the index is BYTE0.
  - When it reaches 0 with the index not BYTE0, the index returns to BYTE0, dropped pulses, and the counter reloads.
  - If rx_valid arrives in the same cycle the counter reaches 0, the byte wins: it is stored and no drop occurs.
- Undefined: no counter is synthesized, dropped is tied to 0, and a partial word waits indefinitely.

## Structure
- Shared package uart_pkg holds:
  - typedef byte_t (logic [7:0]) and typedef word_t (logic [31:0]);
  - localparam BYTES_PER_WORD = 4;
  - the assembler state enum (BYTE0..BYTE3).
- The FIFO is a separate sub-module, uart_word_fifo, parameterized by DEPTH. Its ports are push/pop/data/level/full/empty with first-word fall-through.
- The top module contains the FSM, lane register, overflow flag and optional timeout counter.

## Test plan
- Single word: bytes 8'h11, 8'h22, 8'h33, 8'h44 with word_ready=1 -> one word 32'h44332211, with word_valid high for exactly 1 cycle, 1 cycle after byte 3.
- Backpressure fill: word_ready=0, 5 words sent with DEPTH=4 -> level 4, overflow=1 after word 5; draining yields words 1–4 in order, and word 5 is absent.
- Full plus simultaneous pop: FIFO at DEPTH, with byte 3 arriving in the same cycle as a pop -> word accepted, level stays 4, overflow stays 0.
- Timeout (macro defined, TIMEOUT=100): send 2 bytes, then idle for 100 cycles -> dropped pulses once. Next 4 bytes AA, BB, CC, DD -> 32'hDDCCBBAA. Without the macro, the same stimulus gives 32'hBBAA<b2><b1>.
- Reset mid-operation: 3 bytes sent with 2 words queued, then reset for 1 cycle -> level 0, word_valid 0, overflow 0. Next 4 bytes form a fresh word.
- Consecutive strobes: rx_valid for 4 consecutive cycles with bytes 01, 02, 03, 04 -> 32'h04030201.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types for the UART byte-to-word path.
package uart_pkg;

    typedef logic [7:0]  byte_t;
    typedef logic [31:0] word_t;

    localparam int unsigned BYTES_PER_WORD = 4;

    // Byte lane that the next received byte lands in.
    typedef enum logic [1:0] {
        BYTE0 = 2'd0,
        BYTE1 = 2'd1,
        BYTE2 = 2'd2,
        BYTE3 = 2'd3
    } asm_state_e;

endpackage

// File: rtl/uart_word_fifo.sv
// Synchronous first-word fall-through FIFO of 32-bit words.
// A push into a full FIFO is accepted only when a pop happens on the same edge.
module uart_word_fifo
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    localparam int unsigned PtrW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  word_t         push_data,
    input  logic          pop,
    output word_t         pop_data,
    output logic [PtrW:0] level,
    output logic          full,
    output logic          empty
);

    word_t               mem_q [DEPTH];
    logic [PtrW-1:0]     wr_ptr_q;
    logic [PtrW-1:0]     rd_ptr_q;
    logic [PtrW:0]       level_q;
    logic                pop_ok;
    logic                push_ok;

    assign empty    = (level_q == '0);
    assign full     = (level_q == (PtrW + 1)'(DEPTH));
    assign level    = level_q;
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    // Gate the head so the output reads zero whenever nothing is held.
    assign pop_data = empty ? '0 : mem_q[rd_ptr_q];

    // Storage array; written only on accepted pushes, needs no reset.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    // Pointers and occupancy counter; level is tracked independently of the pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            unique case ({push_ok, pop_ok})
                2'b10:   level_q <= level_q + 1'b1;
                2'b01:   level_q <= level_q - 1'b1;
                default: level_q <= level_q;
            endcase
        end
    end

endmodule

// File: rtl/uart_word_assembler.sv
// Packs UART receiver bytes little-endian into 32-bit words and queues them.
// Optional inter-byte timeout that discards stalled partial words: UART_WORD_TIMEOUT_EN.
module uart_word_assembler
    import uart_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter logic [19:0] TIMEOUT = 20'd34760
) (
    input  logic                     clk,
    input  logic                     reset,
    input  byte_t                    rx_data,
    input  logic                     rx_valid,
    output word_t                    word_data,
    output logic                     word_valid,
    input  logic                     word_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     overflow,
    output logic                     dropped
);

    localparam int unsigned Lanes = BYTES_PER_WORD - 1;

    asm_state_e state_q, state_d;
    byte_t      lane_q [Lanes];
    logic       overflow_q;
    logic       word_push;
    logic       word_pop;
    logic       fifo_full;
    logic       fifo_empty;
    word_t      word_in;

`ifdef UART_WORD_TIMEOUT_EN
    logic [19:0] cnt_q, cnt_d;
    logic        dropped_q, drop_d;
`endif

    // The last byte bypasses the lanes and goes straight into the FIFO.
    assign word_in    = {rx_data, lane_q[2], lane_q[1], lane_q[0]};
    assign word_push  = rx_valid && (state_q == BYTE3);
    assign word_pop   = word_valid && word_ready;
    assign word_valid = !fifo_empty;
    assign overflow   = overflow_q;

    uart_word_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (word_push),
        .push_data (word_in),
        .pop       (word_pop),
        .pop_data  (word_data),
        .level     (level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Next byte index, plus timeout countdown and drop decision when enabled.
    always_comb begin
        state_d = state_q;
`ifdef UART_WORD_TIMEOUT_EN
        cnt_d  = cnt_q;
        drop_d = 1'b0;
`endif
        if (rx_valid) begin
            unique case (state_q)
                BYTE0:   state_d = BYTE1;
                BYTE1:   state_d = BYTE2;
                BYTE2:   state_d = BYTE3;
                default: state_d = BYTE0;
            endcase
`ifdef UART_WORD_TIMEOUT_EN
            // A byte arriving on the expiry cycle wins over the drop.
            cnt_d = TIMEOUT;
        end else if (state_q != BYTE0) begin
            if (cnt_q == '0) begin
                state_d = BYTE0;
                drop_d  = 1'b1;
                cnt_d   = TIMEOUT;
            end else begin
                cnt_d = cnt_q - 20'd1;
            end
`endif
        end
    end

    // State, overflow flag and optional timeout registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= BYTE0;
            overflow_q <= 1'b0;
`ifdef UART_WORD_TIMEOUT_EN
            cnt_q      <= TIMEOUT;
            dropped_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            if (word_push && fifo_full && !word_pop) begin
                overflow_q <= 1'b1;
            end
`ifdef UART_WORD_TIMEOUT_EN
            cnt_q     <= cnt_d;
            dropped_q <= drop_d;
`endif
        end
    end

    // Partial-word lanes; never cleared on completion, later bytes overwrite them.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < Lanes; i++) begin
                lane_q[i] <= '0;
            end
        end else if (rx_valid) begin
            unique case (state_q)
                BYTE0:   lane_q[0] <= rx_data;
                BYTE1:   lane_q[1] <= rx_data;
                BYTE2:   lane_q[2] <= rx_data;
                default: ;
            endcase
        end
    end

`ifdef UART_WORD_TIMEOUT_EN
    assign dropped = dropped_q;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign dropped        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_word_assembler.sv
// Directed bench for uart_word_assembler with a word scoreboard.
module tb_uart_word_assembler;
    import uart_pkg::*;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    byte_t      rx_data = '0;
    logic       rx_valid = 1'b0;
    word_t      word_data;
    logic       word_valid;
    logic       word_ready = 1'b0;
    logic [2:0] level;
    logic       overflow;
    logic       dropped;

    int    checks = 0;
    int    errors = 0;
    word_t exp_q[$];

    uart_word_assembler #(
        .DEPTH   (4),
        .TIMEOUT (20'd100)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .word_data  (word_data),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .level      (level),
        .overflow   (overflow),
        .dropped    (dropped)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every accepted word must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_word: observed %h expected none", word_data);
            end
            if (exp_q.size() != 0) begin
                check("word_data", word_data, exp_q.pop_front());
            end
        end
    end

    task automatic send_byte(input byte_t b);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk); #1;
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input word_t w);
        for (int i = 0; i < 4; i++) begin
            send_byte(w[8*i +: 8]);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n;
        word_ready = 1'b1;
        n = 0;
        while ((exp_q.size() != 0 || word_valid) && n < 20) begin
            idle(1);
            n++;
        end
        check({tag, "_queue_empty"}, exp_q.size(), 0);
        check({tag, "_level"}, 32'(level), 0);
    endtask

    initial begin
        int    drops;
        word_t w;

        // Reset state.
        idle(2);
        reset = 1'b0;
        check("rst_word_valid", 32'(word_valid), 0);
        check("rst_word_data", word_data, 0);
        check("rst_level", 32'(level), 0);
        check("rst_overflow", 32'(overflow), 0);
        check("rst_dropped", 32'(dropped), 0);

        // Single word, valid for exactly one cycle.
        word_ready = 1'b1;
        exp_q.push_back(32'h44332211);
        send_word(32'h44332211);
        check("single_valid_rise", 32'(word_valid), 1);
        idle(1);
        check("single_valid_fall", 32'(word_valid), 0);
        check("single_level", 32'(level), 0);

        // Backpressure fill; fifth word is lost.
        word_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            w = {8'(i), 8'hC0, 8'hB0, 8'hA0};
            if (i <= 4) exp_q.push_back(w);
            send_word(w);
        end
        check("fill_level", 32'(level), 4);
        check("fill_overflow", 32'(overflow), 1);
        check("fill_head", word_data, 32'h01C0B0A0);
        drain("fill");
        pulse_reset();
        check("ovf_cleared", 32'(overflow), 0);

        // Full FIFO with a pop on the same edge as byte 3.
        word_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            w = {8'(i), 8'h33, 8'h22, 8'h11};
            exp_q.push_back(w);
            send_word(w);
        end
        exp_q.push_back(32'hDEADBEEF);
        send_byte(8'hEF);
        send_byte(8'hBE);
        send_byte(8'hAD);
        @(posedge clk); #1;
        rx_valid   = 1'b1;
        rx_data    = 8'hDE;
        word_ready = 1'b1;
        @(posedge clk); #1;
        rx_valid   = 1'b0;
        word_ready = 1'b0;
        check("fullpop_level", 32'(level), 4);
        check("fullpop_overflow", 32'(overflow), 0);
        drain("fullpop");

        // Inter-byte timeout.
        word_ready = 1'b1;
        send_byte(8'h5A);
        send_byte(8'hA5);
        drops = 0;
        for (int i = 0; i < 130; i++) begin
            idle(1);
            if (dropped) drops++;
        end
`ifdef UART_WORD_TIMEOUT_EN
        check("timeout_drops", drops, 1);
        exp_q.push_back(32'hDDCCBBAA);
`else
        check("timeout_drops", drops, 0);
        exp_q.push_back(32'hBBAAA55A);
`endif
        send_word(32'hDDCCBBAA);
        drain("timeout");
        pulse_reset();

        // Reset mid-word with words queued.
        word_ready = 1'b0;
        send_word(32'h12345678);
        send_word(32'h9ABCDEF0);
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        check("pre_reset_level", 32'(level), 2);
        pulse_reset();
        check("post_reset_level", 32'(level), 0);
        check("post_reset_valid", 32'(word_valid), 0);
        check("post_reset_overflow", 32'(overflow), 0);
        word_ready = 1'b1;
        exp_q.push_back(32'hCAFEF00D);
        send_word(32'hCAFEF00D);
        drain("fresh");

        // Strobes on consecutive cycles.
        exp_q.push_back(32'h04030201);
        @(posedge clk); #1;
        rx_valid = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            rx_data = 8'(i);
            @(posedge clk); #1;
        end
        rx_valid = 1'b0;
        drain("consecutive");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
